// File: rtl/float_to_integer_pipe.sv
// Three-stage pipelined binary32 to signed INT_WIDTH-bit integer converter.
// Stages are unpack, align, then round/pack, sharing one stall signal.
module float_to_integer_pipe #(
  parameter int unsigned INT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          a,
  input  logic [1:0]           rm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INT_WIDTH-1:0] d,
  output logic                 p_lost,
  output logic                 denorm,
  output logic                 invalid
);

  localparam int unsigned MW = INT_WIDTH + 1;
  localparam int unsigned EW = MW + 23;
  localparam logic [MW-1:0]        MaxPosMag = {2'b00, {(INT_WIDTH-1){1'b1}}};
  localparam logic [MW-1:0]        MaxNegMag = {2'b01, {(INT_WIDTH-1){1'b0}}};
  localparam logic [INT_WIDTH-1:0] MinInt    = {1'b1, {(INT_WIDTH-1){1'b0}}};

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // S1: unpack
  logic              v1_q, sign1_q, zero1_q, den1_q, spec1_q;
  logic [1:0]        rm1_q;
  logic signed [9:0] exp1_q, exp1_d;
  logic [23:0]       sig1_q, sig1_d;
  logic              zero1_d, den1_d, spec1_d;

  always_comb begin
    exp1_d  = $signed({2'b00, a[30:23]}) - 10'sd127;
    sig1_d  = {a[30:23] != 8'd0, a[22:0]};
    zero1_d = (a[30:23] == 8'd0) && (a[22:0] == 23'd0);
    den1_d  = (a[30:23] == 8'd0) && (a[22:0] != 23'd0);
    spec1_d = (a[30:23] == 8'hff);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      v1_q    <= 1'b0;
      sign1_q <= 1'b0;
      zero1_q <= 1'b0;
      den1_q  <= 1'b0;
      spec1_q <= 1'b0;
      rm1_q   <= 2'b00;
      exp1_q  <= '0;
      sig1_q  <= '0;
    end else if (advance) begin
      v1_q <= in_valid;
      if (in_valid) begin
        sign1_q <= a[31];
        zero1_q <= zero1_d;
        den1_q  <= den1_d;
        spec1_q <= spec1_d;
        rm1_q   <= rm;
        exp1_q  <= exp1_d;
        sig1_q  <= sig1_d;
      end
    end
  end

  // S2: align so the binary point sits just below bit 0 of the magnitude
  logic          v2_q, sign2_q, guard2_q, sticky2_q, inv2_q, den2_q;
  logic [1:0]    rm2_q;
  logic [MW-1:0] mag2_q, mag2_d;
  logic          guard2_d, sticky2_d, inv2_d;
  logic [EW-1:0] shifted;

  always_comb begin
    shifted   = EW'(sig1_q) << exp1_q[6:0];
    mag2_d    = '0;
    guard2_d  = 1'b0;
    sticky2_d = 1'b0;
    inv2_d    = 1'b0;
    if (spec1_q) begin
      inv2_d = 1'b1;
    end else if (zero1_q) begin
      inv2_d = 1'b0;
    end else if (den1_q) begin
      // Nonzero but far below one half: only the sticky bit survives.
      sticky2_d = 1'b1;
    end else if (exp1_q >= $signed(10'(INT_WIDTH))) begin
      inv2_d = 1'b1;
    end else if (exp1_q == -10'sd1) begin
      guard2_d  = 1'b1;
      sticky2_d = |sig1_q[22:0];
    end else if (exp1_q < -10'sd1) begin
      sticky2_d = 1'b1;
    end else begin
      mag2_d    = shifted[EW-1:23];
      guard2_d  = shifted[22];
      sticky2_d = |shifted[21:0];
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      v2_q      <= 1'b0;
      sign2_q   <= 1'b0;
      guard2_q  <= 1'b0;
      sticky2_q <= 1'b0;
      inv2_q    <= 1'b0;
      den2_q    <= 1'b0;
      rm2_q     <= 2'b00;
      mag2_q    <= '0;
    end else if (advance) begin
      v2_q <= v1_q;
      if (v1_q) begin
        sign2_q   <= sign1_q;
        guard2_q  <= guard2_d;
        sticky2_q <= sticky2_d;
        inv2_q    <= inv2_d;
        den2_q    <= den1_q;
        rm2_q     <= rm1_q;
        mag2_q    <= mag2_d;
      end
    end
  end

  // S3: round, range check, negate
  logic                 inc, ovf, inv3;
  logic [MW-1:0]        mag_r;
  logic [INT_WIDTH-1:0] res, d_d;
  logic                 p_lost_d;

  always_comb begin
    inc = 1'b0;
    case (rm2_q)
      2'b00:   inc = guard2_q && (sticky2_q || mag2_q[0]);
      2'b01:   inc = sign2_q && (guard2_q || sticky2_q);
      2'b10:   inc = !sign2_q && (guard2_q || sticky2_q);
      default: inc = 1'b0;
    endcase
    mag_r    = mag2_q + MW'(inc);
    ovf      = sign2_q ? (mag_r > MaxNegMag) : (mag_r > MaxPosMag);
    inv3     = inv2_q || ovf;
    res      = sign2_q ? -mag_r[INT_WIDTH-1:0] : mag_r[INT_WIDTH-1:0];
    d_d      = inv3 ? MinInt : res;
    p_lost_d = !inv3 && (guard2_q || sticky2_q);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      out_valid <= 1'b0;
      d         <= '0;
      p_lost    <= 1'b0;
      denorm    <= 1'b0;
      invalid   <= 1'b0;
    end else if (advance) begin
      out_valid <= v2_q;
      if (v2_q) begin
        d       <= d_d;
        p_lost  <= p_lost_d;
        denorm  <= den2_q;
        invalid <= inv3;
      end
    end
  end

endmodule

// File: tb/tb_float_to_integer_pipe.sv
// Directed bench for float_to_integer_pipe: vector table on 32- and 16-bit instances,
// plus backpressure and mid-flight reset sequences.
module tb_float_to_integer_pipe;

  logic        clk;
  logic        clrn;
  logic        in_valid32, in_ready32, out_valid32, out_ready32;
  logic [31:0] a32, d32;
  logic [1:0]  rm32;
  logic        pl32, dn32, iv32;
  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [31:0] a16;
  logic [15:0] d16;
  logic [1:0]  rm16;
  logic        pl16, dn16, iv16;

  int total = 0;
  int bad   = 0;

  float_to_integer_pipe #(.INT_WIDTH(32)) dut32 (
    .clk(clk), .clrn(clrn), .in_valid(in_valid32), .in_ready(in_ready32), .a(a32), .rm(rm32),
    .out_valid(out_valid32), .out_ready(out_ready32), .d(d32), .p_lost(pl32), .denorm(dn32),
    .invalid(iv32)
  );

  float_to_integer_pipe #(.INT_WIDTH(16)) dut16 (
    .clk(clk), .clrn(clrn), .in_valid(in_valid16), .in_ready(in_ready16), .a(a16), .rm(rm16),
    .out_valid(out_valid16), .out_ready(out_ready16), .d(d16), .p_lost(pl16), .denorm(dn16),
    .invalid(iv16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one operand into an idle pipe and wait for its result.
  task automatic run_one(input logic [31:0] av, input logic [1:0] rmv, input bit w16,
                         output logic [31:0] dv, output logic [2:0] fl, output int lat);
    @(posedge clk); #1;
    if (w16) begin
      a16 = av; rm16 = rmv; in_valid16 = 1'b1;
    end else begin
      a32 = av; rm32 = rmv; in_valid32 = 1'b1;
    end
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    in_valid16 = 1'b0;
    lat = 1;
    while (!(w16 ? out_valid16 : out_valid32) && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    dv = w16 ? {16'h0000, d16} : d32;
    fl = w16 ? {pl16, dn16, iv16} : {pl32, dn32, iv32};
  endtask

  typedef struct {
    logic [31:0] a;
    logic [1:0]  rm;
    bit          w16;
    logic [31:0] d;
    logic [2:0]  fl;  // {p_lost, denorm, invalid}
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] dv;
  logic [2:0]  fl;
  int          lat;

  initial begin
    vecs.push_back('{32'h3fc00000, 2'd0, 1'b0, 32'h00000002, 3'b100});
    vecs.push_back('{32'h3fc00000, 2'd1, 1'b0, 32'h00000001, 3'b100});
    vecs.push_back('{32'h3fc00000, 2'd2, 1'b0, 32'h00000002, 3'b100});
    vecs.push_back('{32'h3fc00000, 2'd3, 1'b0, 32'h00000001, 3'b100});
    vecs.push_back('{32'h40200000, 2'd0, 1'b0, 32'h00000002, 3'b100});
    vecs.push_back('{32'hc0200000, 2'd0, 1'b0, 32'hfffffffe, 3'b100});
    vecs.push_back('{32'hc0200000, 2'd1, 1'b0, 32'hfffffffd, 3'b100});
    vecs.push_back('{32'h3f800000, 2'd0, 1'b0, 32'h00000001, 3'b000});
    vecs.push_back('{32'h4effffff, 2'd0, 1'b0, 32'h7fffff80, 3'b000});
    vecs.push_back('{32'hcf000000, 2'd0, 1'b0, 32'h80000000, 3'b000});
    vecs.push_back('{32'hcf000001, 2'd0, 1'b0, 32'h80000000, 3'b001});
    vecs.push_back('{32'h4f000000, 2'd0, 1'b0, 32'h80000000, 3'b001});
    vecs.push_back('{32'h46fffe00, 2'd0, 1'b1, 32'h00007fff, 3'b000});
    vecs.push_back('{32'h46ffff00, 2'd0, 1'b1, 32'h00008000, 3'b001});
    vecs.push_back('{32'h7f800000, 2'd0, 1'b0, 32'h80000000, 3'b001});
    vecs.push_back('{32'hff800000, 2'd0, 1'b0, 32'h80000000, 3'b001});
    vecs.push_back('{32'h7fc00000, 2'd0, 1'b0, 32'h80000000, 3'b001});
    vecs.push_back('{32'h80000000, 2'd0, 1'b0, 32'h00000000, 3'b000});
    vecs.push_back('{32'h00000001, 2'd3, 1'b0, 32'h00000000, 3'b110});
    vecs.push_back('{32'h00000001, 2'd2, 1'b0, 32'h00000001, 3'b110});
    vecs.push_back('{32'h80000001, 2'd1, 1'b0, 32'hffffffff, 3'b110});
    vecs.push_back('{32'hbf7fffff, 2'd3, 1'b0, 32'h00000000, 3'b100});
    vecs.push_back('{32'hbf7fffff, 2'd1, 1'b0, 32'hffffffff, 3'b100});

    clrn = 1'b0;
    in_valid32 = 1'b0; a32 = '0; rm32 = '0; out_ready32 = 1'b1;
    in_valid16 = 1'b0; a16 = '0; rm16 = '0; out_ready16 = 1'b1;
    #2;
    check("reset_out_valid", {31'd0, out_valid32}, 32'd0);
    check("reset_d", d32, 32'd0);
    check("reset_flags", {29'd0, pl32, dn32, iv32}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready32}, 32'd1);
    @(posedge clk); #1;
    clrn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_one(vecs[i].a, vecs[i].rm, vecs[i].w16, dv, fl, lat);
      check($sformatf("vec%0d_d", i), dv, vecs[i].d);
      check($sformatf("vec%0d_flags", i), {29'd0, fl}, {29'd0, vecs[i].fl});
      check($sformatf("vec%0d_latency", i), lat, 32'd3);
    end

    // Backpressure: 1.0..4.0 back-to-back, consumer stalls 2 cycles at the first result.
    begin
      logic [31:0] vals[4];
      logic [31:0] got[$];
      logic [31:0] held_d;
      int          sent, stall;
      bit          first_seen;
      vals[0] = 32'h3f800000; vals[1] = 32'h40000000;
      vals[2] = 32'h40400000; vals[3] = 32'h40800000;
      sent = 0; stall = 0; first_seen = 0; held_d = '0;
      rm32 = 2'd0;
      for (int cyc = 0; cyc < 40; cyc++) begin
        @(posedge clk); #1;
        if (!first_seen && out_valid32) begin
          first_seen = 1;
          stall = 2;
          held_d = d32;
        end
        out_ready32 = (stall == 0);
        in_valid32 = (sent < 4);
        if (sent < 4) a32 = vals[sent];
        @(negedge clk);
        if (stall > 0) begin
          check("stall_in_ready", {31'd0, in_ready32}, 32'd0);
          check("stall_hold_d", d32, held_d);
          stall--;
        end
        if (in_valid32 && in_ready32) sent++;
        if (out_valid32 && out_ready32) got.push_back(d32);
        if (sent == 4 && got.size() == 4) break;
      end
      @(posedge clk); #1;
      in_valid32 = 1'b0;
      out_ready32 = 1'b1;
      check("bp_count", got.size(), 32'd4);
      for (int i = 0; i < 4; i++) begin
        if (i < got.size()) check($sformatf("bp_result%0d", i), got[i], i + 1);
        else check($sformatf("bp_result%0d", i), 32'hxxxxxxxx, i + 1);
      end
    end

    // Reset with three operands in flight.
    begin
      logic [31:0] ops[3];
      int          seen;
      ops[0] = 32'h40a00000; ops[1] = 32'h40c00000; ops[2] = 32'h40e00000;
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        a32 = ops[i]; in_valid32 = 1'b1;
      end
      @(posedge clk); #1;
      in_valid32 = 1'b0;
      clrn = 1'b0;
      #1;
      check("rst_mid_out_valid", {31'd0, out_valid32}, 32'd0);
      check("rst_mid_d", d32, 32'd0);
      @(posedge clk); #1;
      clrn = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        if (out_valid32) seen++;
      end
      check("rst_no_stale", seen, 32'd0);
      run_one(32'h3f800000, 2'd0, 1'b0, dv, fl, lat);
      check("rst_after_d", dv, 32'd1);
      check("rst_after_latency", lat, 32'd3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
